// File: rtl/snn_axi_lite_regfile.sv
// AXI4-Lite register file: CTRL, SEL, spike-generator thresholds and a synapse-write window.
// Latency: BVALID/RVALID one cycle after acceptance; backpressure: each channel stalls in RESP until BREADY/RREADY.
module snn_axi_lite_regfile #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 16,
    parameter int NUM_INPUTS         = 9,
    parameter int WEIGHT_SIZE        = 9
) (
    input  logic                                     S_AXI_ACLK,
    input  logic                                     S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic                                     S_AXI_AWVALID,
    output logic                                     S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
    input  logic                                     S_AXI_WVALID,
    output logic                                     S_AXI_WREADY,
    output logic [1:0]                               S_AXI_BRESP,
    output logic                                     S_AXI_BVALID,
    input  logic                                     S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic                                     S_AXI_ARVALID,
    output logic                                     S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                               S_AXI_RRESP,
    output logic                                     S_AXI_RVALID,
    input  logic                                     S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]            ctrl_reg,
    output logic [C_S_AXI_DATA_WIDTH*NUM_INPUTS-1:0] spike_gen_regs,
    output logic                                     syn_wr_en,
    output logic [3:0]                               syn_layer,
    output logic [19:0]                              syn_neuron,
    output logic [7:0]                               syn_index,
    output logic [WEIGHT_SIZE-1:0]                   syn_weight
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam logic [AW-1:0] ADDR_CTRL = '0;
    localparam logic [AW-1:0] ADDR_SEL  = AW'(4);

    typedef enum logic {CH_IDLE, CH_RESP} ch_state_e;

    ch_state_e wr_state_q, wr_state_d;
    ch_state_e rd_state_q, rd_state_d;

    logic [DW-1:0]          ctrl_q;
    logic [DW-1:0]          sel_q;
    logic [DW-1:0]          spike_q [NUM_INPUTS];
    logic [DW-1:0]          rdata_q;
    logic [DW-1:0]          rd_mux;
    logic                   syn_wr_en_q;
    logic [3:0]             syn_layer_q;
    logic [19:0]            syn_neuron_q;
    logic [7:0]             syn_index_q;
    logic [WEIGHT_SIZE-1:0] syn_weight_q;
    logic                   wr_accept;
    logic                   rd_accept;
    logic                   unused_wstrb;

    function automatic logic is_window(input logic [AW-1:0] a);
        return a[AW-1:8] == (AW-8)'(1);
    endfunction

    // Both AW and W must be present together; a lone channel is never acked.
    assign wr_accept = S_AXI_AWVALID & S_AXI_WVALID & (wr_state_q == CH_IDLE) & ~S_AXI_ARESET;
    assign rd_accept = S_AXI_ARVALID & (rd_state_q == CH_IDLE) & ~S_AXI_ARESET;

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            CH_IDLE: if (wr_accept)    wr_state_d = CH_RESP;
            CH_RESP: if (S_AXI_BREADY) wr_state_d = CH_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            CH_IDLE: if (rd_accept)    rd_state_d = CH_RESP;
            CH_RESP: if (S_AXI_RREADY) rd_state_d = CH_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wr_state_q <= CH_IDLE;
            rd_state_q <= CH_IDLE;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            ctrl_q       <= '0;
            sel_q        <= '0;
            syn_wr_en_q  <= 1'b0;
            syn_layer_q  <= '0;
            syn_neuron_q <= '0;
            syn_index_q  <= '0;
            syn_weight_q <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                spike_q[i] <= '0;
            end
        end else begin
            syn_wr_en_q <= 1'b0;
            if (wr_accept) begin
                if (S_AXI_AWADDR == ADDR_CTRL) begin
                    ctrl_q <= S_AXI_WDATA;
                end else if (S_AXI_AWADDR == ADDR_SEL) begin
                    sel_q <= S_AXI_WDATA;
                end else if (is_window(S_AXI_AWADDR)) begin
                    if (sel_q[7:0] == 8'd0) begin
                        // Indices beyond the last generator fall through untouched.
                        for (int i = 0; i < NUM_INPUTS; i++) begin
                            if (S_AXI_AWADDR[7:0] == 8'(i)) begin
                                spike_q[i] <= S_AXI_WDATA;
                            end
                        end
                    end else if (sel_q[7:0] == 8'd1) begin
                        syn_wr_en_q  <= 1'b1;
                        syn_layer_q  <= sel_q[31:28];
                        syn_neuron_q <= sel_q[27:8];
                        syn_index_q  <= S_AXI_AWADDR[7:0];
                        syn_weight_q <= S_AXI_WDATA[WEIGHT_SIZE-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (S_AXI_ARADDR == ADDR_CTRL) begin
            rd_mux = ctrl_q;
        end else if (S_AXI_ARADDR == ADDR_SEL) begin
            rd_mux = sel_q;
        end else if (is_window(S_AXI_ARADDR) && (sel_q[7:0] == 8'd0)) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (S_AXI_ARADDR[7:0] == 8'(i)) begin
                    rd_mux = spike_q[i];
                end
            end
        end
    end

    // Captured on the acceptance edge, so a same-cycle write is not yet visible.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rdata_q <= '0;
        end else if (rd_accept) begin
            rdata_q <= rd_mux;
        end
    end

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_flat
        assign spike_gen_regs[g*DW +: DW] = spike_q[g];
    end

    assign unused_wstrb  = ^S_AXI_WSTRB;

    assign S_AXI_AWREADY = wr_accept;
    assign S_AXI_WREADY  = wr_accept;
    assign S_AXI_BVALID  = (wr_state_q == CH_RESP);
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = rd_accept;
    assign S_AXI_RVALID  = (rd_state_q == CH_RESP);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;

    assign ctrl_reg      = ctrl_q;
    assign syn_wr_en     = syn_wr_en_q;
    assign syn_layer     = syn_layer_q;
    assign syn_neuron    = syn_neuron_q;
    assign syn_index     = syn_index_q;
    assign syn_weight    = syn_weight_q;

endmodule

// File: tb/tb_snn_axi_lite_regfile.sv
// Directed bench for snn_axi_lite_regfile: vector table plus handshake, backpressure and reset sequences.
module tb_snn_axi_lite_regfile;

    localparam int NI = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   awaddr, araddr;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [1:0]    bresp, rresp;
    logic [31:0]   rdata, ctrl_reg;
    logic [32*NI-1:0] spike_gen_regs;
    logic          syn_wr_en;
    logic [3:0]    syn_layer;
    logic [19:0]   syn_neuron;
    logic [7:0]    syn_index;
    logic [8:0]    syn_weight;

    int n_chk  = 0;
    int n_fail = 0;
    int syn_cnt = 0;
    logic [3:0]  syn_l;
    logic [19:0] syn_n;
    logic [7:0]  syn_i;
    logic [8:0]  syn_w;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] dat;   // write data, or expected read data
    } vec_t;
    vec_t vecs[$];

    snn_axi_lite_regfile dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .ctrl_reg      (ctrl_reg),
        .spike_gen_regs(spike_gen_regs),
        .syn_wr_en     (syn_wr_en),
        .syn_layer     (syn_layer),
        .syn_neuron    (syn_neuron),
        .syn_index     (syn_index),
        .syn_weight    (syn_weight)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (syn_wr_en) begin
            syn_cnt++;
            syn_l = syn_layer;
            syn_n = syn_neuron;
            syn_i = syn_index;
            syn_w = syn_weight;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = 4'h0; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        #1;
        while (!(awready && wready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("wr_ready", {31'b0, awready && wready}, 32'd1);
        @(posedge clk); #1;
        chk("wr_ready_pulse", {30'b0, awready, wready}, 32'd0);
        chk("bvalid", {31'b0, bvalid}, 32'd1);
        chk("bresp", {30'b0, bresp}, 32'd0);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        chk("bvalid_clr", {31'b0, bvalid}, 32'd0);
    endtask

    task automatic axi_read(input logic [15:0] a, output logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        #1;
        while (!arready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("ar_ready", {31'b0, arready}, 32'd1);
        @(posedge clk); #1;
        chk("ar_ready_pulse", {31'b0, arready}, 32'd0);
        chk("rvalid", {31'b0, rvalid}, 32'd1);
        chk("rresp", {30'b0, rresp}, 32'd0);
        d = rdata;
        arvalid = 1'b0;
        @(posedge clk); #1;
        chk("rvalid_hold", {31'b0, rvalid}, 32'd1);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        chk("rvalid_clr", {31'b0, rvalid}, 32'd0);
    endtask

    initial begin
        logic [31:0] step;
        logic [31:0] rd;
        int          base;
        step = 32'hFFFF_FFFF / 32'd9;

        vecs.push_back('{1'b1, 16'h0000, 32'hDEAD_BEEF});
        vecs.push_back('{1'b0, 16'h0000, 32'hDEAD_BEEF});
        vecs.push_back('{1'b1, 16'h0004, 32'h0000_0000});
        for (int i = 0; i < NI; i++) vecs.push_back('{1'b1, 16'h0100 + 16'(i), step * 32'(i)});
        for (int i = 0; i < NI; i++) vecs.push_back('{1'b0, 16'h0100 + 16'(i), step * 32'(i)});
        vecs.push_back('{1'b1, 16'h0109, 32'hCAFE_F00D});
        vecs.push_back('{1'b0, 16'h0109, 32'h0000_0000});
        vecs.push_back('{1'b1, 16'h0200, 32'h1234_5678});
        vecs.push_back('{1'b0, 16'h0200, 32'h0000_0000});
        vecs.push_back('{1'b0, 16'h0008, 32'h0000_0000});
        vecs.push_back('{1'b0, 16'h0004, 32'h0000_0000});

        // Reset with both request channels active: nothing may be acked.
        rst = 1'b1; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", {31'b0, awready}, 32'd0);
        chk("rst_arready", {31'b0, arready}, 32'd0);
        chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ctrl", ctrl_reg, 32'd0);
        chk("rst_syn_wr_en", {31'b0, syn_wr_en}, 32'd0);
        for (int i = 0; i < NI; i++) chk("rst_spike", spike_gen_regs[32*i +: 32], 32'd0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk); rst = 1'b0;

        foreach (vecs[k]) begin
            if (vecs[k].wr) begin
                axi_write(vecs[k].addr, vecs[k].dat);
            end else begin
                axi_read(vecs[k].addr, rd);
                chk("vec_read", rd, vecs[k].dat);
            end
        end
        chk("ctrl_out", ctrl_reg, 32'hDEAD_BEEF);
        for (int i = 0; i < NI; i++) chk("spike_entry", spike_gen_regs[32*i +: 32], step * 32'(i));
        chk("no_syn_mode0", 32'(syn_cnt), 32'd0);

        // Synapse window, mode 1.
        axi_write(16'h0004, 32'h0000_0101);
        axi_write(16'h0103, 32'd7);
        chk("syn_cnt1", 32'(syn_cnt), 32'd1);
        chk("syn_layer1", {28'b0, syn_l}, 32'd0);
        chk("syn_neuron1", {12'b0, syn_n}, 32'd1);
        chk("syn_index1", {24'b0, syn_i}, 32'd3);
        chk("syn_weight1", {23'b0, syn_w}, 32'd7);
        axi_read(16'h0103, rd);
        chk("syn_window_read", rd, 32'd0);
        axi_write(16'h0004, 32'h5ABC_DE01);
        axi_write(16'h01FF, 32'hFFFF_F1FF);
        chk("syn_cnt2", 32'(syn_cnt), 32'd2);
        chk("syn_layer2", {28'b0, syn_l}, 32'd5);
        chk("syn_neuron2", {12'b0, syn_n}, 32'h000A_BCDE);
        chk("syn_index2", {24'b0, syn_i}, 32'h0000_00FF);
        chk("syn_weight2", {23'b0, syn_w}, 32'h0000_01FF);

        // Mode 2: window write dropped, entry 1 untouched, still OKAY.
        axi_write(16'h0004, 32'h0000_0002);
        axi_write(16'h0101, 32'h0BAD_0BAD);
        chk("mode2_syn_cnt", 32'(syn_cnt), 32'd2);
        chk("mode2_entry1", spike_gen_regs[63:32], step);

        // BREADY held low: second pair must wait.
        axi_write(16'h0004, 32'h0000_0000);
        @(negedge clk);
        awaddr = 16'h0000; wdata = 32'h1111_1111; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1;
        wdata = 32'h2222_2222;
        for (int c = 0; c < 5; c++) begin
            chk("bp_bvalid_hold", {31'b0, bvalid}, 32'd1);
            chk("bp_no_accept", {30'b0, awready, wready}, 32'd0);
            @(posedge clk); #1;
        end
        chk("bp_ctrl_first", ctrl_reg, 32'h1111_1111);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        chk("bp_bvalid_clr", {31'b0, bvalid}, 32'd0);
        chk("bp_second_ready", {30'b0, awready, wready}, 32'd3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bp_second_bvalid", {31'b0, bvalid}, 32'd1);
        chk("bp_ctrl_second", ctrl_reg, 32'h2222_2222);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;

        // Read and write of CTRL accepted on the same edge: read returns the old value.
        @(negedge clk);
        awaddr = 16'h0000; wdata = 32'h3333_3333; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 16'h0000; arvalid = 1'b1;
        #1;
        chk("rw_both_ready", {29'b0, awready, wready, arready}, 32'd7);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("rw_bvalid", {31'b0, bvalid}, 32'd1);
        chk("rw_rvalid", {31'b0, rvalid}, 32'd1);
        chk("rw_old_rdata", rdata, 32'h2222_2222);
        chk("rw_new_ctrl", ctrl_reg, 32'h3333_3333);
        bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        chk("rw_done", {30'b0, bvalid, rvalid}, 32'd0);

        // Reset while RVALID is pending, and a mode-1 write presented during reset.
        axi_write(16'h0004, 32'h0000_0001);
        @(negedge clk);
        araddr = 16'h0000; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("pre_rst_rvalid", {31'b0, rvalid}, 32'd1);
        rst = 1'b1;
        awaddr = 16'h0105; wdata = 32'd9; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("mid_rst_bvalid", {31'b0, bvalid}, 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_ctrl", ctrl_reg, 32'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_syn", 32'(syn_cnt), 32'd2);
        for (int i = 0; i < NI; i++) chk("mid_rst_spike", spike_gen_regs[32*i +: 32], 32'd0);
        @(negedge clk); rst = 1'b0;
        base = syn_cnt;
        axi_read(16'h0000, rd); chk("post_rst_ctrl", rd, 32'd0);
        axi_read(16'h0004, rd); chk("post_rst_sel", rd, 32'd0);
        axi_read(16'h0108, rd); chk("post_rst_entry8", rd, 32'd0);
        chk("post_rst_no_syn", 32'(syn_cnt), 32'(base));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/snn_axi_lite_regfile.md
SNN_AXI_LITE_REGFILE -- requirements
Module: snn_axi_lite_regfile

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 16, AXI address width.
REQ-003 SHALL have parameter NUM_INPUTS, default 9, number of spike-generator registers.
REQ-004 SHALL have parameter WEIGHT_SIZE, default 9, synapse weight width.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports as follows.
- S_AXI_ACLK  in  1  clock; all logic on rising edge.
- S_AXI_ARESET  in  1  synchronous active-high reset.
- S_AXI_AWADDR/AWVALID/AWREADY  in/in/out  16/1/1  write address channel.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR/ARVALID/ARREADY  in/in/out  16/1/1  read address channel.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel.
- ctrl_reg  out  32  contents of CTRL.
- spike_gen_regs  out  32*NUM_INPUTS  flattened spike-generator thresholds; entry i is at bits [32i+31:32i].
- syn_wr_en  out  1  one-cycle synapse write strobe.
- syn_layer/syn_neuron/syn_index  out  4/20/8  synapse write target.
- syn_weight  out  WEIGHT_SIZE  synapse weight, taken from WDATA[WEIGHT_SIZE-1:0].

Function
REQ-006 Addresses SHALL be register indices, not byte-scaled; the map is as follows.
- 0x0000: CTRL, read/write.
- 0x0004: SEL, read/write, with fields [31:28] layer, [27:8] neuron, [7:0] mode.
- 0x0100-0x01FF: data window; index = addr[7:0].
REQ-007 WSTRB SHALL be ignored; every write is full-word.
REQ-008 Write path: AWREADY and WREADY SHALL both pulse high for exactly one cycle when AWVALID=1, WVALID=1 and BVALID=0.
- Neither channel is accepted alone.
- Any channel waiting alone stays un-acked.
REQ-009 BVALID SHALL rise the cycle after the AW/W acceptance and hold until sampled with BREADY=1; BRESP SHALL be 2'b00.
REQ-010 No new write SHALL be accepted while BVALID=1.
REQ-011 The register update SHALL occur on the acceptance edge, and is visible the cycle after.
REQ-012 Window write with SEL.mode=0 and index<NUM_INPUTS SHALL update spike-gen entry[index]; index>=NUM_INPUTS SHALL be ignored.
REQ-013 Window write with SEL.mode=1 SHALL pulse syn_wr_en for one cycle, the cycle after acceptance, with the following qualifiers valid in that cycle; no local storage.
- syn_layer and syn_neuron from SEL.
- syn_index from addr[7:0].
- syn_weight from WDATA.
REQ-014 Window writes with other mode values, and writes to unmapped addresses, SHALL be dropped but still SHALL receive BVALID with OKAY.
REQ-015 Read path: ARREADY SHALL pulse one cycle when ARVALID=1 and RVALID=0.
- RVALID and RDATA are registered the next cycle and held stable until RREADY=1.
- RRESP SHALL be 2'b00.
REQ-016 Read data SHALL be as follows.
- CTRL and SEL return their contents.
- Window with mode=0 and index<NUM_INPUTS returns the entry.
- Everything else returns 0.
REQ-017 Read and write channels SHALL be independent.
- A read and a write accepted in the same cycle both complete.
- A read of the register written that cycle returns the old value.
REQ-018 Each channel SHALL follow a 2-state FSM, IDLE -> RESP on acceptance and RESP -> IDLE on the ready handshake; back-to-back transactions are allowed the cycle after RESP exits.

Reset
REQ-019 While S_AXI_ARESET=1, all outputs and registers SHALL be 0 on the next edge, including:
- AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA;
- CTRL, SEL, spike_gen_regs;
- syn_wr_en.
REQ-020 Reset asserted mid-transaction SHALL abort it: the pending BVALID/RVALID is dropped and no syn_wr_en is emitted.

Verification
REQ-021 Write 0x0000=0xDEADBEEF with WSTRB=0 -> one-cycle AW/W ready, BVALID with OKAY; a read of 0x0000 returns 0xDEADBEEF.
REQ-022 SEL.mode=0; write 0x0100+i = (0xFFFFFFFF/9)*i for i=0..8 -> spike_gen_regs entries match, and reads of 0x0100+i return the same values.
REQ-023 SEL=0x0000_0101 (layer 0, neuron 1, mode 1); write 0x0103=7 -> one syn_wr_en pulse with layer 0, neuron 1, index 3, weight 7; a read of 0x0103 returns 0.
REQ-024 Hold BREADY=0 for 5 cycles after a write -> BVALID stays high, a second AW/W pair is not accepted, and it is accepted after BREADY.
REQ-025 Assert reset while RVALID=1 -> RVALID=0 the next cycle, and all registers read 0 after reset.
REQ-026 Write 0x0108 with mode=0 and NUM_INPUTS=9 (index 8 valid), then 0x0109 -> 0x0109 is ignored, BVALID still responds, and reading 0x0109 returns 0.
